// File: rtl/proc_pkg.sv
// proc_pkg: shared states, port codes and defaults for the processor job sequencer
package proc_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, GAP, RUN, READ, SEND} state_e;
  localparam logic [2:0] CM_A   = 3'b000;
  localparam logic [2:0] CM_B   = 3'b001;
  localparam logic [2:0] CM_C   = 3'b010;
  localparam logic [2:0] CM_RAM = 3'b011;
  localparam logic [2:0] CM_ROM = 3'b100;
  localparam logic [2:0] CM_NOP = 3'b111;
  localparam logic [2:0] CO_A   = 3'b000;
  localparam logic [2:0] CO_B   = 3'b001;
  localparam logic [2:0] CO_C   = 3'b010;
  localparam logic [2:0] CO_NOP = 3'b111;
  localparam int PIPE_EXTRA_DEF = 2;
  localparam int MAX_PROG_DEF   = 8;
  // RAM auto-increments inside the core, so both RAM bytes share one code
  function automatic logic [2:0] cm_code(input logic [3:0] k);
    return k == 4'd0 ? CM_A : k == 4'd1 ? CM_B : k == 4'd2 ? CM_C : k < 4'd5 ? CM_RAM : CM_ROM;
  endfunction
endpackage

// File: rtl/proc_result_buf.sv
// proc_result_buf: drives the core readback port, captures a/b/c/err and streams them out
module proc_result_buf
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_i,
  input  logic       send_i,
  input  logic [7:0] data_i,
  input  logic [2:0] err_i,
  input  logic       res_ready_i,
  output logic [2:0] ctrl_o,
  output logic       rd_done_o,
  output logic       res_valid_o,
  output logic [7:0] res_data_o,
  output logic       send_done_o
);
  logic [1:0] cnt_q;
  logic [7:0] mem_q [4];
  logic       hs;
  assign hs          = send_i && res_ready_i;
  assign ctrl_o      = !rd_i ? CO_NOP : cnt_q == 2'd0 ? CO_A : cnt_q == 2'd1 ? CO_B : cnt_q == 2'd2 ? CO_C : CO_NOP;
  assign rd_done_o   = rd_i && cnt_q == 2'd3;
  assign res_valid_o = send_i;
  assign res_data_o  = send_i ? mem_q[cnt_q] : 8'd0;
  assign send_done_o = hs && cnt_q == 2'd3;
  // readback data lags its code by one cycle, hence the cnt-1 slot
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      if (rd_i || hs) cnt_q <= cnt_q + 2'd1;
      if (rd_i && cnt_q != 2'd0) mem_q[cnt_q - 2'd1] <= data_i;
      if (rd_done_o) mem_q[3] <= {5'b0, err_i};
    end
endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: loads a job into the 8-bit core, runs it for a fixed budget, returns a/b/c/err
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int PIPE_EXTRA = PIPE_EXTRA_DEF,
  parameter int MAX_PROG   = MAX_PROG_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] prog_len,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  output logic       host_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready,
  output logic       busy,
  output logic       done,
  output logic       err_len,
  output logic       proc_reset_b,
  output logic [2:0] proc_control_mem,
  output logic [7:0] proc_data_in,
  output logic       proc_enable,
  output logic [2:0] proc_control_out,
  input  logic [7:0] proc_data_out,
  input  logic [2:0] proc_error
);
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] len_q;
  logic [2:0] cm_q;
  logic [7:0] din_q;
  logic       rstb_q, done_q, err_q;
  logic       len_ok, hs, last_byte, run_last, rd_done, snd_done;
  assign len_ok           = prog_len != 4'd0 && int'(prog_len) <= MAX_PROG;
  assign hs               = host_ready && host_valid;
  assign last_byte        = cnt_q == 8'(len_q) + 8'd4;
  assign run_last         = cnt_q == 8'(len_q) + 8'(PIPE_EXTRA) - 8'd1;
  assign host_ready       = state_q == LOAD;
  assign busy             = state_q != IDLE;
  assign proc_enable      = state_q == RUN;
  assign proc_reset_b     = rstb_q;
  assign proc_control_mem = cm_q;
  assign proc_data_in     = din_q;
  assign done             = done_q;
  assign err_len          = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      IDLE:  if (start && len_ok) state_d = CLEAR;
      CLEAR: state_d = LOAD;
      LOAD: begin
        cnt_d = hs ? cnt_q + 8'd1 : cnt_q;
        if (hs && last_byte) state_d = GAP;
      end
      GAP:   state_d = RUN;
      RUN:   if (run_last) state_d = READ;
      READ:  if (rd_done) state_d = SEND;
      SEND:  if (snd_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end
  // reset_b is registered from next state so it reads 0 while reset is held
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      cm_q    <= CM_NOP;
      din_q   <= '0;
      rstb_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && start) len_q <= prog_len;
      cm_q    <= hs ? cm_code(cnt_q[3:0]) : CM_NOP;
      if (hs) din_q <= host_data;
      rstb_q  <= state_d != CLEAR;
      done_q  <= snd_done;
      err_q   <= state_q == IDLE && start && !len_ok;
    end
  proc_result_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .rd_i        (state_q == READ),
    .send_i      (state_q == SEND),
    .data_i      (proc_data_out),
    .err_i       (proc_error),
    .res_ready_i (res_ready),
    .ctrl_o      (proc_control_out),
    .rd_done_o   (rd_done),
    .res_valid_o (res_valid),
    .res_data_o  (res_data),
    .send_done_o (snd_done)
  );
endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Job sequencer for the 8-bit processor core. Accepts a job from a host byte stream (initial a/b/c, two RAM bytes, 1–8 instructions), clears the core, loads it through its `control_mem`/`data_in` port, runs it for a fixed cycle budget, then reads back a/b/c plus the error count. The results are returned on a second byte stream. Sits between the host interface and the single processor instance and is the only master of the core's load, enable and readback ports.

## Interface
- `PIPE_EXTRA`, default 2: extra enable cycles beyond `prog_len` that cover the core's fetch/decode pipeline.
- `MAX_PROG`, default 8: maximum instruction count; equals the core ROM depth.
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle job request; sampled only in IDLE.
- `prog_len`, input, 4: number of instructions, valid range 1..8; sampled with `start`.
- `host_valid`, input, 1 / `host_data`, input, 8 / `host_ready`, output, 1: job byte stream.
- `res_valid`, output, 1 / `res_data`, output, 8 / `res_ready`, input, 1: result byte stream.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse after the last result byte is accepted.
- `err_len`, output, 1: one-cycle pulse when `start` arrives with an illegal `prog_len`.
- `proc_reset_b`, output, 1: active-low synchronous reset to the core.
- `proc_control_mem`, output, 3 / `proc_data_in`, output, 8: load port to the core.
- `proc_enable`, output, 1: core run enable.
- `proc_control_out`, output, 3 / `proc_data_out`, input, 8: readback port.
- `proc_error`, input, 3: core error counter.

## Operation
- **Reset values:** FSM goes to IDLE. `host_ready`, `res_valid`, `busy`, `done`, `err_len`, `proc_enable` = 0. `proc_reset_b` = 0, which holds the core in reset. `proc_control_mem` and `proc_control_out` = 3'b111 (no-op). `proc_data_in` and `res_data` = 0.
- **IDLE:** `proc_reset_b` = 1. On `start` with `prog_len` in 1..8, latch `prog_len` and go to CLEAR. With `prog_len` of 0 or greater than 8, pulse `err_len` and stay in IDLE.
- **CLEAR (1 cycle):** `proc_reset_b` = 0, which zeroes the core's program counter, load counters and error count.
- **LOAD:** `host_ready` = 1. Byte index k runs 0..4+`prog_len`. On each handshake, the next cycle drives `proc_data_in` = byte and `proc_control_mem` = code for one cycle; otherwise the code is 3'b111.
  - Codes: k=0 → 000 (a), k=1 → 001 (b), k=2 → 010 (c), k=3 and k=4 → 011 (RAM0, RAM1), k≥5 → 100 (ROM, sequential).
  - After the last byte is accepted, `host_ready` drops in the same cycle it is accepted. One idle cycle follows, then RUN.
- **RUN:** `proc_enable` = 1 for exactly `prog_len`+`PIPE_EXTRA` consecutive cycles, then 0.
- **READ (4 cycles):** drive `proc_control_out` = 000, 001, 010 on consecutive cycles, then 3'b111. Capture `proc_data_out` one cycle after each code. Capture {5'b0, `proc_error`} in the 4th cycle.
- **SEND:** stream the 4 captured bytes in order a, b, c, err. `res_data` is held stable while `res_valid` && !`res_ready`. When the 4th byte is accepted, pulse `done` and return to IDLE.
- **Boundaries:**
  - `start` outside IDLE is ignored.
  - A `host_valid` gap in LOAD stalls the load without losing any byte.
  - `res_ready` held low stalls SEND indefinitely.
  - `prog_len`=8 writes ROM locations 0..7.
  - `reset` in any state aborts the job immediately; nothing is emitted and the core is held in reset.

## Timing
- Cycle 0: `start` sampled. Cycle 1: CLEAR. Cycle 2: `host_ready` rises.
- Load-port latency is 1 cycle after each byte handshake.
- With an uninterrupted host and an always-ready sink, start to `done` is 2 + (5+`prog_len`) + 1 + (`prog_len`+`PIPE_EXTRA`) + 4 + 4 cycles.
- `done` is asserted in the cycle after the 4th result handshake.

## Structure
- Shared package `proc_pkg` holds:
  - the FSM state enum: IDLE, CLEAR, LOAD, GAP, RUN, READ, SEND;
  - control_mem code constants: `CM_A`, `CM_B`, `CM_C`, `CM_RAM`, `CM_ROM`, `CM_NOP`=3'b111;
  - control_out code constants;
  - the default values of `PIPE_EXTRA` and `MAX_PROG`.
- One sub-module, `proc_result_buf`: a 4×8 capture buffer with a valid/ready output pointer that implements READ capture and SEND.

## Test plan
- Job a=3, b=4, c=5, RAM={10,20}, one instruction 0x04 (add a,b) → result bytes 7, 4, 5, 0; `done` once.
- Job with instruction 0x9C (mov b,RAM1), RAM1=0x55 → b result byte is 0x55.
- Job with instruction 0x4C (mov a with a memory operand, illegal) → err result byte is 1.
- `prog_len`=0 and `prog_len`=9 → `err_len` pulses; `busy` stays 0; no `host_ready`.
- Random `host_valid` gaps plus `res_ready` low for 5 cycles mid-SEND → results identical to the gap-free run; `res_data` is stable during the stall.
- `reset` asserted during RUN, then a new job → the first job produces no output and the second job's results are correct.
